// File: rtl/writeback_nlane.sv
//==============================================================================
// Module      : writeback_nlane
// Description : N-lane registered writeback stage. It squashes lanes that are
//               younger than the oldest redirect and arbitrates that redirect
//               into a single pending redirect slot for the front end.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module writeback_nlane #(
    parameter int LANES = 2,
    parameter int XLEN  = 64,
    parameter int SB_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES-1:0]            wb_valid_i,
    input  logic [5*LANES-1:0]          wb_rd_i,
    input  logic [XLEN*LANES-1:0]       wb_value_i,
    input  logic [(SB_W+1)*LANES-1:0]   wb_sid_i,
    input  logic [LANES-1:0]            wb_redirect_i,
    input  logic [XLEN*LANES-1:0]       wb_redirect_pc_i,
    input  logic [LANES-1:0]            stall_i,
    input  logic [LANES-1:0]            flush_i,
    input  logic                        flush_all_i,
    output logic [LANES-1:0]            wb_valid_o,
    output logic [5*LANES-1:0]          wb_rd_o,
    output logic [XLEN*LANES-1:0]       wb_value_o,
    output logic [(SB_W+1)*LANES-1:0]   wb_sid_o,
    output logic                        redirect_valid_o,
    input  logic                        redirect_ready_i,
    output logic [XLEN-1:0]             redirect_pc_o,
    output logic [SB_W:0]               redirect_sid_o
);

    localparam int SID_W = SB_W + 1;

    // Age order of scoreboard ids: the wrap bit flips the sense of the index compare.
    function automatic logic sid_older(input logic [SID_W-1:0] a, input logic [SID_W-1:0] b);
        if (a[SB_W] == b[SB_W]) begin
            return a[SB_W-1:0] < b[SB_W-1:0];
        end
        return a[SB_W-1:0] > b[SB_W-1:0];
    endfunction

    logic [LANES-1:0]             valid_q;
    logic [LANES-1:0]             redir_q;
    logic [LANES-1:0][4:0]        rd_q;
    logic [LANES-1:0][XLEN-1:0]   value_q;
    logic [LANES-1:0][SID_W-1:0]  sid_q;
    logic [LANES-1:0][XLEN-1:0]   pc_q;

    logic                         pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]              pend_pc_q,    pend_pc_d;
    logic [SID_W-1:0]             pend_sid_q,   pend_sid_d;

    logic                         cand_found;
    logic [SID_W-1:0]             cand_sid;
    logic [XLEN-1:0]              cand_pc;
    logic                         accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            redir_q <= '0;
            rd_q    <= '0;
            value_q <= '0;
            sid_q   <= '0;
            pc_q    <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (flush_all_i || flush_i[l]) begin
                    valid_q[l] <= 1'b0;
                    redir_q[l] <= 1'b0;
                end else if (wb_valid_i[l]) begin
                    valid_q[l] <= 1'b1;
                    redir_q[l] <= wb_redirect_i[l];
                    rd_q[l]    <= wb_rd_i[l*5 +: 5];
                    value_q[l] <= wb_value_i[l*XLEN +: XLEN];
                    sid_q[l]   <= wb_sid_i[l*SID_W +: SID_W];
                    pc_q[l]    <= wb_redirect_pc_i[l*XLEN +: XLEN];
                end else if (!stall_i[l]) begin
                    valid_q[l] <= 1'b0;
                    redir_q[l] <= 1'b0;
                end
            end
        end
    end

    // Strict compare while scanning upward, so equal sids resolve to the lower lane.
    always_comb begin
        cand_found = 1'b0;
        cand_sid   = '0;
        cand_pc    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (valid_q[l] && redir_q[l] && !flush_i[l]) begin
                if (!cand_found || sid_older(sid_q[l], cand_sid)) begin
                    cand_found = 1'b1;
                    cand_sid   = sid_q[l];
                    cand_pc    = pc_q[l];
                end
            end
        end
    end

    always_comb begin
        wb_valid_o = '0;
        wb_rd_o    = '0;
        wb_value_o = '0;
        wb_sid_o   = '0;
        for (int l = 0; l < LANES; l++) begin
            wb_valid_o[l] = valid_q[l] & ~flush_i[l] & ~flush_all_i
                          & ~(cand_found & sid_older(cand_sid, sid_q[l]));
            wb_rd_o[l*5 +: 5]            = rd_q[l];
            wb_value_o[l*XLEN +: XLEN]   = value_q[l];
            wb_sid_o[l*SID_W +: SID_W]   = sid_q[l];
        end
    end

    assign accept = pend_valid_q & redirect_ready_i;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_sid_d   = pend_sid_q;
        if (flush_all_i) begin
            pend_valid_d = 1'b0;
        end else if (cand_found && (!pend_valid_q || accept)) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = cand_pc;
            pend_sid_d   = cand_sid;
        end else if (cand_found && sid_older(cand_sid, pend_sid_q)) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = cand_pc;
            pend_sid_d   = cand_sid;
        end else if (accept) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            pend_sid_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_sid_q   <= pend_sid_d;
        end
    end

    assign redirect_valid_o = pend_valid_q;
    assign redirect_pc_o    = pend_pc_q;
    assign redirect_sid_o   = pend_sid_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_nlane.sv
//==============================================================================
// Module      : tb_writeback_nlane
// Description : Scoreboard bench for writeback_nlane: directed scenarios then
//               random traffic against a lane-level behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_writeback_nlane;

    localparam int LANES = 2;
    localparam int XLEN  = 64;
    localparam int SB_W  = 4;
    localparam int SIDW  = SB_W + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [LANES-1:0]        wb_valid_i;
    logic [5*LANES-1:0]      wb_rd_i;
    logic [XLEN*LANES-1:0]   wb_value_i;
    logic [SIDW*LANES-1:0]   wb_sid_i;
    logic [LANES-1:0]        wb_redirect_i;
    logic [XLEN*LANES-1:0]   wb_redirect_pc_i;
    logic [LANES-1:0]        stall_i;
    logic [LANES-1:0]        flush_i;
    logic                    flush_all_i;
    logic [LANES-1:0]        wb_valid_o;
    logic [5*LANES-1:0]      wb_rd_o;
    logic [XLEN*LANES-1:0]   wb_value_o;
    logic [SIDW*LANES-1:0]   wb_sid_o;
    logic                    redirect_valid_o;
    logic                    redirect_ready_i;
    logic [XLEN-1:0]         redirect_pc_o;
    logic [SIDW-1:0]         redirect_sid_o;

    writeback_nlane #(.LANES(LANES), .XLEN(XLEN), .SB_W(SB_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_i          (wb_rd_i),
        .wb_value_i       (wb_value_i),
        .wb_sid_i         (wb_sid_i),
        .wb_redirect_i    (wb_redirect_i),
        .wb_redirect_pc_i (wb_redirect_pc_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .flush_all_i      (flush_all_i),
        .wb_valid_o       (wb_valid_o),
        .wb_rd_o          (wb_rd_o),
        .wb_value_o       (wb_value_o),
        .wb_sid_o         (wb_sid_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_sid_o   (redirect_sid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                    chk;
        logic [LANES-1:0]      v;
        logic [5*LANES-1:0]    rd;
        logic [XLEN*LANES-1:0] val;
        logic [SIDW*LANES-1:0] sid;
        logic                  rv;
        logic [XLEN-1:0]       rpc;
        logic [SIDW-1:0]       rsid;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: one record per lane plus the single pending redirect.
    bit          m_v   [LANES];
    bit          m_r   [LANES];
    logic [4:0]  m_rd  [LANES];
    logic [63:0] m_val [LANES];
    logic [63:0] m_pc  [LANES];
    int          m_sid [LANES];
    bit          p_v;
    logic [63:0] p_pc;
    int          p_sid;

    function automatic bit m_older(int a, int b);
        int wa = a / 16;
        int wb = b / 16;
        int la = a % 16;
        int lb = b % 16;
        if (wa == wb) return la < lb;
        return la > lb;
    endfunction

    task automatic step(input bit chk);
        exp_t e;
        int   best;
        bit   acc;
        best = -1;
        for (int l = 0; l < LANES; l++) begin
            if (m_v[l] && m_r[l] && !flush_i[l]) begin
                if (best < 0 || m_older(m_sid[l], m_sid[best])) best = l;
            end
        end
        e.chk = chk;
        e.v   = '0;
        e.rd  = '0;
        e.val = '0;
        e.sid = '0;
        for (int l = 0; l < LANES; l++) begin
            e.v[l] = m_v[l] && !flush_i[l] && !flush_all_i
                     && !(best >= 0 && m_older(m_sid[best], m_sid[l]));
            e.rd[l*5 +: 5]        = m_rd[l];
            e.val[l*XLEN +: XLEN] = m_val[l];
            e.sid[l*SIDW +: SIDW] = SIDW'(m_sid[l]);
        end
        e.rv   = p_v;
        e.rpc  = p_pc;
        e.rsid = SIDW'(p_sid);
        exp_q.push_back(e);

        if (!rst_n) begin
            p_v = 0; p_pc = '0; p_sid = 0;
            for (int l = 0; l < LANES; l++) begin
                m_v[l] = 0; m_r[l] = 0; m_rd[l] = '0; m_val[l] = '0; m_pc[l] = '0; m_sid[l] = 0;
            end
        end else begin
            acc = p_v && redirect_ready_i;
            if (flush_all_i) p_v = 0;
            else if (best >= 0 && (!p_v || acc || m_older(m_sid[best], p_sid))) begin
                p_v = 1; p_pc = m_pc[best]; p_sid = m_sid[best];
            end else if (acc) p_v = 0;
            for (int l = 0; l < LANES; l++) begin
                if (flush_all_i || flush_i[l]) begin
                    m_v[l] = 0; m_r[l] = 0;
                end else if (wb_valid_i[l]) begin
                    m_v[l]   = 1;
                    m_r[l]   = wb_redirect_i[l];
                    m_rd[l]  = wb_rd_i[l*5 +: 5];
                    m_val[l] = wb_value_i[l*XLEN +: XLEN];
                    m_pc[l]  = wb_redirect_pc_i[l*XLEN +: XLEN];
                    m_sid[l] = int'(wb_sid_i[l*SIDW +: SIDW]);
                end else if (!stall_i[l]) begin
                    m_v[l] = 0; m_r[l] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                vectors++;
                if (wb_valid_o !== e.v) begin
                    miscompares++;
                    $display("FAIL wb_valid_o t=%0t got=%b exp=%b", $time, wb_valid_o, e.v);
                end
                if (wb_rd_o !== e.rd) begin
                    miscompares++;
                    $display("FAIL wb_rd_o t=%0t got=%h exp=%h", $time, wb_rd_o, e.rd);
                end
                if (wb_value_o !== e.val) begin
                    miscompares++;
                    $display("FAIL wb_value_o t=%0t got=%h exp=%h", $time, wb_value_o, e.val);
                end
                if (wb_sid_o !== e.sid) begin
                    miscompares++;
                    $display("FAIL wb_sid_o t=%0t got=%h exp=%h", $time, wb_sid_o, e.sid);
                end
                if (redirect_valid_o !== e.rv) begin
                    miscompares++;
                    $display("FAIL redirect_valid_o t=%0t got=%b exp=%b", $time, redirect_valid_o, e.rv);
                end
                if (redirect_pc_o !== e.rpc) begin
                    miscompares++;
                    $display("FAIL redirect_pc_o t=%0t got=%h exp=%h", $time, redirect_pc_o, e.rpc);
                end
                if (redirect_sid_o !== e.rsid) begin
                    miscompares++;
                    $display("FAIL redirect_sid_o t=%0t got=%h exp=%h", $time, redirect_sid_o, e.rsid);
                end
            end
        end
    end

    task automatic clr_in();
        rst_n            = 1'b1;
        wb_valid_i       = '0;
        wb_redirect_i    = '0;
        stall_i          = '0;
        flush_i          = '0;
        flush_all_i      = 1'b0;
        redirect_ready_i = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] rd, input logic [63:0] val,
                            input logic [SIDW-1:0] sid, input bit redir, input logic [63:0] pc);
        wb_valid_i[l]                  = 1'b1;
        wb_rd_i[l*5 +: 5]              = rd;
        wb_value_i[l*XLEN +: XLEN]     = val;
        wb_sid_i[l*SIDW +: SIDW]       = sid;
        wb_redirect_i[l]               = redir;
        wb_redirect_pc_i[l*XLEN +: XLEN] = pc;
    endtask

    task automatic kill_all();
        clr_in();
        flush_all_i = 1'b1;
        step(1);
        clr_in();
    endtask

    task automatic rand_inputs();
        clr_in();
        for (int l = 0; l < LANES; l++) begin
            wb_valid_i[l]                    = ($urandom_range(0, 99) < 60);
            wb_rd_i[l*5 +: 5]                = 5'($urandom);
            wb_value_i[l*XLEN +: XLEN]       = {$urandom, $urandom};
            wb_sid_i[l*SIDW +: SIDW]         = SIDW'($urandom_range(0, 31));
            wb_redirect_i[l]                 = ($urandom_range(0, 99) < 40);
            wb_redirect_pc_i[l*XLEN +: XLEN] = {$urandom, $urandom};
            stall_i[l]                       = ($urandom_range(0, 99) < 30);
            flush_i[l]                       = ($urandom_range(0, 99) < 8);
        end
        if ($urandom_range(0, 99) < 20) wb_sid_i[SIDW +: SIDW] = wb_sid_i[0 +: SIDW];
        flush_all_i      = ($urandom_range(0, 99) < 3);
        redirect_ready_i = ($urandom_range(0, 99) < 40);
        rst_n            = !($urandom_range(0, 199) == 0);
    endtask

    initial begin
        wb_rd_i = '0; wb_value_i = '0; wb_sid_i = '0; wb_redirect_pc_i = '0;
        clr_in();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step(0);
        clr_in();
        step(1);

        // Lane 1 only, no cross-lane capture
        set_lane(1, 5'd5, 64'hABCD, 5'h00, 1'b0, 64'h0);
        step(1);
        clr_in();
        step(1);

        // Both redirect; lane1 older, lane0 squashed
        set_lane(0, 5'd1, 64'h11, 5'h03, 1'b1, 64'h1000);
        set_lane(1, 5'd2, 64'h22, 5'h02, 1'b1, 64'h2000);
        step(1);
        clr_in();
        stall_i = '1;
        step(1);
        step(1);
        kill_all();

        // Wrap case: lane0 older
        set_lane(0, 5'd3, 64'h33, 5'h1E, 1'b1, 64'h3000);
        set_lane(1, 5'd4, 64'h44, 5'h01, 1'b1, 64'h4000);
        step(1);
        clr_in();
        stall_i = '1;
        step(1);
        step(1);
        kill_all();

        // Older replacement, younger ignored until accepted
        set_lane(0, 5'd6, 64'h55, 5'h05, 1'b1, 64'h5000);
        step(1);
        clr_in();
        step(1);
        set_lane(0, 5'd7, 64'h66, 5'h04, 1'b1, 64'h6000);
        step(1);
        clr_in();
        step(1);
        set_lane(0, 5'd8, 64'h77, 5'h07, 1'b1, 64'h7000);
        step(1);
        clr_in();
        step(1);
        step(1);
        redirect_ready_i = 1'b1;
        step(1);
        clr_in();
        step(1);

        // Stall hold then flush
        set_lane(0, 5'd9, 64'h3, 5'h08, 1'b0, 64'h0);
        step(1);
        clr_in();
        stall_i = 2'b01;
        step(1);
        step(1);
        step(1);
        flush_i = 2'b01;
        step(1);
        clr_in();
        step(1);

        // Reset mid-handshake
        set_lane(1, 5'd10, 64'h88, 5'h0A, 1'b1, 64'h8000);
        step(1);
        clr_in();
        stall_i = 2'b10;
        step(1);
        rst_n = 1'b0;
        step(1);
        clr_in();
        step(1);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step(1);
        end
        clr_in();
        step(1);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
